// File: rtl/memory_access_arbiter_pkg.sv
// Shared types, size codes and timeout limit for the memory access arbiter.
package memory_access_arbiter_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned SIZE_W        = 2;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned TIMEOUT_LIMIT = 255;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [SIZE_W-1:0] SIZE_BYTE    = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_HALF    = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_WORD    = 2'b10;
  localparam logic [SIZE_W-1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_TRAP  = 3'd4
  } state_e;

  // Command held on the memory port for the duration of an access.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw;
    logic [SIZE_W-1:0] size;
  } mem_cmd_t;

  // A data request traps on an illegal size or a misaligned address.
  function automatic logic data_trap(input logic [SIZE_W-1:0] size, input logic [1:0] lo);
    logic trap;
    case (size)
      SIZE_BYTE: trap = 1'b0;
      SIZE_HALF: trap = lo[0];
      SIZE_WORD: trap = (lo != 2'b00);
      default:   trap = 1'b1;
    endcase
    return trap;
  endfunction

  // Store data is replicated across every lane; the memory picks the lane by size/address.
  function automatic logic [DATA_W-1:0] replicate_store(input logic [SIZE_W-1:0] size,
                                                        input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{wdata[7:0]}};
      SIZE_HALF: lanes = {2{wdata[15:0]}};
      default:   lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/memory_access_arbiter_load_align.sv
// Big-endian load lane extraction with zero/sign extension.
module load_align
  import memory_access_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [SIZE_W-1:0] size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Select the addressed lane (offset 0 is the most significant) and right-justify it.
  always_comb begin
    byte_c = rdata[31:24];
    half_c = rdata[31:16];
    data_c = rdata;
    case (addr_lo)
      2'b01:   byte_c = rdata[23:16];
      2'b10:   byte_c = rdata[15:8];
      2'b11:   byte_c = rdata[7:0];
      default: byte_c = rdata[31:24];
    endcase
    if (addr_lo[1]) begin
      half_c = rdata[15:0];
    end
    case (size)
      SIZE_BYTE: data_c = {{24{sign_ext & byte_c[7]}}, byte_c};
      SIZE_HALF: data_c = {{16{sign_ext & half_c[15]}}, half_c};
      default:   data_c = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single handshaked memory port.
module memory_access_arbiter
  import memory_access_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [SIZE_W-1:0] d_size,
  input  logic              d_signed,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              d_trap,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic [SIZE_W-1:0] mem_size,
  output logic              mem_mov,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_moc,
  output logic              bus_err
);

  state_e            state, next_state;
  logic [CNT_W-1:0]  wait_cnt;
  mem_cmd_t          mem_cmd;
  logic              owner_data;
  logic              req_signed;

  logic              active_c, timeout_c, trap_req_c;
  logic              accept_d_c, accept_if_c, complete_c;
  logic [DATA_W-1:0] load_data_c;
  logic              if_gnt_nxt, d_gnt_nxt, if_done_nxt, d_done_nxt;
  logic              d_trap_nxt, bus_err_nxt, mov_nxt;

  assign active_c   = (state == ST_ISSUE) || (state == ST_WAIT);
  assign timeout_c  = active_c && !mem_moc && (wait_cnt == CNT_W'(TIMEOUT_LIMIT - 1));
  assign trap_req_c = data_trap(d_size, d_addr[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: data wins arbitration; MOC is only looked at while accessing.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (d_req)       next_state = trap_req_c ? ST_TRAP : ST_ISSUE;
        else if (if_req) next_state = ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (mem_moc)        next_state = ST_DONE;
        else if (timeout_c) next_state = ST_IDLE;
        else                next_state = ST_WAIT;
      end
      ST_DONE: next_state = ST_IDLE;
      ST_TRAP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake pulses and port controls.
  always_comb begin
    accept_d_c  = 1'b0;
    accept_if_c = 1'b0;
    complete_c  = 1'b0;
    if_gnt_nxt  = 1'b0;
    d_gnt_nxt   = 1'b0;
    if_done_nxt = 1'b0;
    d_done_nxt  = 1'b0;
    d_trap_nxt  = 1'b0;
    bus_err_nxt = 1'b0;
    mov_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_req) begin
          accept_d_c = !trap_req_c;
          d_gnt_nxt  = !trap_req_c;
          mov_nxt    = !trap_req_c;
          d_trap_nxt = trap_req_c;
        end else if (if_req) begin
          accept_if_c = 1'b1;
          if_gnt_nxt  = 1'b1;
          mov_nxt     = 1'b1;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (mem_moc) begin
          complete_c  = 1'b1;
          d_done_nxt  = owner_data;
          if_done_nxt = !owner_data;
        end else if (timeout_c) begin
          bus_err_nxt = 1'b1;
          d_done_nxt  = owner_data;
          if_done_nxt = !owner_data;
        end else begin
          mov_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Handshake pulse and MOV registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      d_trap  <= 1'b0;
      bus_err <= 1'b0;
      mem_mov <= 1'b0;
    end else begin
      if_gnt  <= if_gnt_nxt;
      d_gnt   <= d_gnt_nxt;
      if_done <= if_done_nxt;
      d_done  <= d_done_nxt;
      d_trap  <= d_trap_nxt;
      bus_err <= bus_err_nxt;
      mem_mov <= mov_nxt;
    end
  end

  // Wait counter: cleared on grant, counts access cycles that saw no MOC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt <= '0;
    else if (next_state == ST_ISSUE) wait_cnt <= '0;
    else if (active_c && !mem_moc) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Capture the winning request; the memory port stays stable until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cmd    <= '{addr: '0, wdata: '0, rw: RW_READ, size: '0};
      owner_data <= 1'b0;
      req_signed <= 1'b0;
    end else if (accept_d_c) begin
      mem_cmd    <= '{addr: d_addr, wdata: replicate_store(d_size, d_wdata), rw: d_rw, size: d_size};
      owner_data <= 1'b1;
      req_signed <= d_signed;
    end else if (accept_if_c) begin
      mem_cmd    <= '{addr: if_addr & ~ADDR_W'(3), wdata: '0, rw: RW_READ, size: SIZE_WORD};
      owner_data <= 1'b0;
      req_signed <= 1'b0;
    end
  end

  assign mem_addr  = mem_cmd.addr;
  assign mem_wdata = mem_cmd.wdata;
  assign mem_rw    = mem_cmd.rw;
  assign mem_size  = mem_cmd.size;

  load_align u_load_align (
    .rdata    (mem_rdata),
    .addr_lo  (mem_cmd.addr[1:0]),
    .size     (mem_cmd.size),
    .sign_ext (req_signed),
    .data_c   (load_data_c)
  );

  // Read data registers: updated on read completion, zeroed on timeout, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rdata <= '0;
      if_data <= '0;
    end else if (timeout_c) begin
      if (owner_data) d_rdata <= '0;
      else            if_data <= '0;
    end else if (complete_c && (mem_cmd.rw == RW_READ)) begin
      if (owner_data) d_rdata <= load_data_c;
      else            if_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed self-checking bench for memory_access_arbiter.
module tb_memory_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_done;
  logic [31:0] if_data;
  logic        d_req, d_rw, d_signed;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_done, d_trap;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rw, mem_mov;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_moc;
  logic        bus_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  memory_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_trap(d_trap), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_mov(mem_mov), .mem_rdata(mem_rdata), .mem_moc(mem_moc), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
    d_req = 1'b1; d_rw = 1'b1; d_size = size; d_signed = sgn; d_addr = addr;
    mem_moc = 1'b1; mem_rdata = rdata;
    tick();
    chk1({tag, "_gnt"}, d_gnt, 1'b1);
    tick();
    chk1({tag, "_done"}, d_done, 1'b1);
    chk32({tag, "_rdata"}, d_rdata, exp);
    exp_rdata = exp;
    d_req = 1'b0; mem_moc = 1'b0;
    tick();
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [31:0] exp_lanes);
    d_req = 1'b1; d_rw = 1'b0; d_size = size; d_signed = 1'b0; d_addr = addr; d_wdata = wdata;
    mem_moc = 1'b0;
    tick();
    chk1({tag, "_mov"}, mem_mov, 1'b1);
    chk32({tag, "_wdata"}, mem_wdata, exp_lanes);
    chk1({tag, "_rw"}, mem_rw, 1'b0);
    chk32({tag, "_size"}, 32'(mem_size), 32'(size));
    mem_moc = 1'b1;
    tick();
    chk1({tag, "_done"}, d_done, 1'b1);
    chk32({tag, "_rdata_held"}, d_rdata, exp_rdata);
    d_req = 1'b0; mem_moc = 1'b0;
    tick();
  endtask

  task automatic do_trap(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic rw);
    d_req = 1'b1; d_rw = rw; d_size = size; d_addr = addr; mem_moc = 1'b1;
    tick();
    chk1({tag, "_trap"}, d_trap, 1'b1);
    chk1({tag, "_mov"}, mem_mov, 1'b0);
    chk1({tag, "_done"}, d_done, 1'b0);
    d_req = 1'b0;
    tick();
    chk1({tag, "_trap_end"}, d_trap, 1'b0);
    chk1({tag, "_mov_end"}, mem_mov, 1'b0);
    mem_moc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mov_cycles;
    int guard;
    int done_seen;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_rw = 1'b1; d_size = 2'b10;
    d_signed = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_moc = 1'b0;
    #12;
    chk1("rst_mov", mem_mov, 1'b0);
    chk1("rst_rw", mem_rw, 1'b1);
    chk32("rst_addr", mem_addr, 32'h0);
    chk32("rst_wdata", mem_wdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk32("rst_if_data", if_data, 32'h0);
    chk1("rst_gnt", d_gnt | if_gnt, 1'b0);
    chk1("rst_done", d_done | if_done | d_trap | bus_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Fetch with MOC returning in cycle 4 -> IF_Done in cycle 5
    if_req = 1'b1; if_addr = 32'h0000_0102;
    tick();
    chk1("f_gnt", if_gnt, 1'b1);
    chk1("f_mov1", mem_mov, 1'b1);
    chk32("f_addr", mem_addr, 32'h0000_0100);
    chk1("f_rw", mem_rw, 1'b1);
    chk32("f_size", 32'(mem_size), 32'd2);
    tick();
    chk1("f_gnt_pulse", if_gnt, 1'b0);
    chk1("f_mov2", mem_mov, 1'b1);
    tick();
    chk1("f_mov3", mem_mov, 1'b1);
    tick();
    chk1("f_mov4", mem_mov, 1'b1);
    chk32("f_addr_stable", mem_addr, 32'h0000_0100);
    chk1("f_no_early_done", if_done, 1'b0);
    mem_moc = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk1("f_done", if_done, 1'b1);
    chk32("f_data", if_data, 32'hDEAD_BEEF);
    chk1("f_mov_off", mem_mov, 1'b0);
    if_req = 1'b0; mem_moc = 1'b0;
    tick();
    chk1("f_done_pulse", if_done, 1'b0);
    chk32("f_data_held", if_data, 32'hDEAD_BEEF);

    // Simultaneous requests: data first, fetch in the IDLE after D_Done
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h80; mem_moc = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    chk1("arb_d_gnt", d_gnt, 1'b1);
    chk1("arb_if_wait", if_gnt, 1'b0);
    chk32("arb_addr_d", mem_addr, 32'h40);
    tick();
    chk1("arb_d_done", d_done, 1'b1);
    chk32("arb_d_rdata", d_rdata, 32'h1122_3344);
    chk1("arb_if_no_done", if_done, 1'b0);
    d_req = 1'b0;
    tick();
    chk1("arb_idle_no_gnt", if_gnt, 1'b0);
    chk1("arb_idle_mov", mem_mov, 1'b0);
    tick();
    chk1("arb_if_gnt", if_gnt, 1'b1);
    chk32("arb_addr_if", mem_addr, 32'h80);
    tick();
    chk1("arb_if_done", if_done, 1'b1);
    chk32("arb_if_data", if_data, 32'h1122_3344);
    chk32("arb_d_rdata_held", d_rdata, 32'h1122_3344);
    if_req = 1'b0; mem_moc = 1'b0;
    tick();

    // Loads: lane selection and extension
    do_load("ld_sb01", 32'h0000_1001, 2'b00, 1'b1, 32'h1280_3456, 32'hFFFF_FF80);
    do_load("ld_ub01", 32'h0000_1001, 2'b00, 1'b0, 32'h1280_3456, 32'h0000_0080);
    do_load("ld_ub00", 32'h0000_1000, 2'b00, 1'b0, 32'h1280_3456, 32'h0000_0012);
    do_load("ld_sb11", 32'h0000_1003, 2'b00, 1'b1, 32'h0000_00FF, 32'hFFFF_FFFF);
    do_load("ld_sh10", 32'h0000_1002, 2'b01, 1'b1, 32'h1234_8001, 32'hFFFF_8001);
    do_load("ld_uh00", 32'h0000_1000, 2'b01, 1'b0, 32'hABCD_0000, 32'h0000_ABCD);

    // Stores: lane replication
    do_store("st_b", 32'h0000_0203, 2'b00, 32'h0000_00A5, 32'hA5A5_A5A5);
    do_store("st_h", 32'h0000_0202, 2'b01, 32'h1234_BEEF, 32'hBEEF_BEEF);
    do_store("st_w", 32'h0000_0204, 2'b10, 32'h0102_0304, 32'h0102_0304);

    // Traps: misalignment and illegal size
    do_trap("tr_h03", 32'h0000_0003, 2'b01, 1'b0);
    do_trap("tr_sz11", 32'h0000_0004, 2'b11, 1'b0);
    do_trap("tr_w02", 32'h0000_0002, 2'b10, 1'b1);

    // Timeout: MOC never returns
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h300; mem_moc = 1'b0;
    tick();
    mov_cycles = 0;
    guard = 0;
    while (!bus_err && guard < 400) begin
      if (mem_mov) mov_cycles++;
      guard++;
      tick();
    end
    d_req = 1'b0;
    chk1("to_bus_err", bus_err, 1'b1);
    chk32("to_mov_cycles", 32'(mov_cycles), 32'd255);
    chk1("to_done", d_done, 1'b1);
    chk32("to_rdata", d_rdata, 32'h0);
    chk1("to_mov", mem_mov, 1'b0);
    tick();
    chk1("to_bus_err_pulse", bus_err, 1'b0);
    chk1("to_done_pulse", d_done, 1'b0);

    // Reset during WAIT: abandoned, then normal service
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h400; mem_moc = 1'b0;
    tick();
    chk1("rw_mov1", mem_mov, 1'b1);
    tick();
    chk1("rw_mov2", mem_mov, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rw_async_mov", mem_mov, 1'b0);
    chk32("rw_async_addr", mem_addr, 32'h0);
    chk1("rw_async_rw", mem_rw, 1'b1);
    d_req = 1'b0;
    #2 rst_n = 1'b1;
    mem_moc = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (d_done || if_done || mem_mov) done_seen++;
    end
    chk32("rw_no_done", 32'(done_seen), 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0503; mem_rdata = 32'hCAFE_F00D;
    tick();
    chk1("rw_if_gnt", if_gnt, 1'b1);
    chk32("rw_if_addr", mem_addr, 32'h0000_0500);
    tick();
    chk1("rw_if_done", if_done, 1'b1);
    chk32("rw_if_data", if_data, 32'hCAFE_F00D);
    if_req = 1'b0; mem_moc = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
